// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor and counter-width helpers.
// Used by the transmitter today and by the receiver later.
package uart_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_REQ    = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd2;
  localparam logic [STATE_W-1:0] ST_START  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd4;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd5;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd6;

  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Never narrower than one bit, so a divide-by-1 build still elaborates.
  function automatic int baud_cnt_w(input int clk_freq, input int baud_rate);
    int div;
    div = baud_div(clk_freq, baud_rate);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..BAUD_DIV-1 while en is high, tick on the last count.
// Latency: tick is combinational from the count; counter restarts at 0 the cycle after en drops.
// Backpressure: none; en simply freezes the counter at 0.
module uart_baud_gen import uart_pkg::*; #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  output logic tick
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = baud_cnt_w(CLK_FREQ, BAUD_RATE);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Drains a standard-mode FIFO and serialises each byte as start/data(LSB first)/[parity]/stop on tx.
// Latency: start bit begins 2 cycles after fifo_rd_en; back-to-back frames have a 2-cycle tx-high gap.
// Backpressure: one read in flight at most; next read only after the stop bit. UART_TX_PARITY_EN adds even parity.
module uart_tx_fifo_drain import uart_pkg::*; #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_W    = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              tx,
  output logic              busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [DATA_W-1:0]  shreg, shreg_nxt;
  logic [BIT_W-1:0]   bit_idx, bit_idx_nxt;
  logic               tick;
  logic               baud_en;
  logic               tx_nxt;
`ifdef UART_TX_PARITY_EN
  logic               par, par_nxt;
`endif

  // Counter held at 0 outside the line bits so every frame starts phase-aligned.
  assign baud_en = (state != ST_IDLE) && (state != ST_REQ) && (state != ST_LOAD);

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (baud_en),
    .tick      (tick)
  );

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_idx_nxt = bit_idx;
`ifdef UART_TX_PARITY_EN
    par_nxt     = par;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_nxt   = fifo_dout;
        bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
        par_nxt     = 1'b0;
`endif
        state_nxt   = ST_START;
      end
      ST_START: begin
        if (tick) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shreg_nxt   = shreg >> 1;
          bit_idx_nxt = bit_idx + BIT_W'(1);
`ifdef UART_TX_PARITY_EN
          par_nxt     = par ^ shreg[0];
`endif
          if (bit_idx == LAST_BIT) begin
            bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt   = ST_PARITY;
`else
            state_nxt   = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_nxt = fifo_empty ? ST_IDLE : ST_REQ;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // tx is registered from the next state so the line bit lines up with the state it belongs to.
    tx_nxt = 1'b1;
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_nxt = par_nxt;
`endif
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_idx <= bit_idx_nxt;
      tx      <= tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      par <= 1'b0;
    end else begin
      par <= par_nxt;
    end
  end
`endif

  assign fifo_rd_en = (state == ST_REQ);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: frame-level model checked every cycle, plus literal checks
// and a second 9600-baud instance timed from its tx edges.
module tb_uart_tx_fifo_drain;

  localparam int DIV  = 50_000_000 / 115200;  // 434
  localparam int DIV2 = 50_000_000 / 9600;    // 5208
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = 2 + NB * DIV;        // rd_en cycle to the cycle after the stop bit
  localparam int HMAX  = 70000;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       rst2_n    = 1'b0;
  logic       fifo_empty, fifo_rd_en, tx, busy;
  logic [7:0] fifo_dout = 8'h00;
  logic       f2_empty, f2_rd_en, tx2, busy2;
  logic [7:0] f2_dout   = 8'h00;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  uart_tx_fifo_drain #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_W(8)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .tx(tx), .busy(busy));

  uart_tx_fifo_drain #(.CLK_FREQ(50_000_000), .BAUD_RATE(9600), .DATA_W(8)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst_n(rst2_n), .fifo_empty(f2_empty), .fifo_rd_en(f2_rd_en),
    .fifo_dout(f2_dout), .tx(tx2), .busy(busy2));

  // Standard-mode FIFO stand-ins: data appears the cycle after the read strobe.
  logic [7:0] mem [0:63];
  int n_push = 0;
  int n_pop  = 0;
  assign fifo_empty = (n_push == n_pop);
  always @(posedge sys_clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[n_pop % 64];
      n_pop     <= n_pop + 1;
    end
  end

  int p2_push = 0;
  int p2_pop  = 0;
  assign f2_empty = (p2_push == p2_pop);
  always @(posedge sys_clk) begin
    if (f2_rd_en) begin
      f2_dout <= 8'h55;
      p2_pop  <= p2_pop + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line bit k of a frame carrying byte b.
  function automatic logic fbit(input logic [7:0] b, input int k);
    logic [2:0] ix;
    if (k == 0) return 1'b0;
    if (k <= 8) begin
      ix = 3'(k - 1);
      return b[ix];
    end
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Frame-level model: a frame occupies FRAME cycles starting at its rd_en cycle.
  logic       m_act  = 1'b0;
  int         m_off  = 0;
  logic [7:0] m_byte = 8'h00;
  int         m_rd   = 0;

  logic txh [0:HMAX-1];
  logic bh  [0:HMAX-1];
  int   rd_times[$];
  int   falls[$];
  int   busy_falls[$];
  logic prev_tx   = 1'b1;
  logic prev_busy = 1'b0;

  always @(negedge sys_clk) begin
    logic e_rd, e_busy, e_tx;
    e_rd = 1'b0; e_busy = 1'b0; e_tx = 1'b1;
    if (sys_rst_n && m_act) begin
      e_rd   = (m_off == 0);
      e_busy = 1'b1;
      if (m_off >= 2) e_tx = fbit(m_byte, (m_off - 2) / DIV);
    end
    chk("model rd_en/busy/tx", {fifo_rd_en, busy, tx}, {e_rd, e_busy, e_tx});

    if (cyc < HMAX) begin
      txh[cyc] = tx;
      bh[cyc]  = busy;
    end
    if (fifo_rd_en) rd_times.push_back(cyc);
    if (prev_tx && !tx) falls.push_back(cyc);
    if (prev_busy && !busy) busy_falls.push_back(cyc);
    prev_tx   = tx;
    prev_busy = busy;

    if (!sys_rst_n) begin
      m_act = 1'b0;
    end else begin
      if (m_act) begin
        m_off++;
        if (m_off == FRAME) m_act = 1'b0;
      end
      if (!m_act && (m_rd != n_push)) begin
        m_act  = 1'b1;
        m_off  = 0;
        m_byte = mem[m_rd % 64];
        m_rd++;
      end
    end
  end

  // 9600-baud instance monitor.
  int   edges2[$];
  int   rd2_cnt  = 0;
  int   b2_fall  = -1;
  logic prev_tx2 = 1'b1;
  logic prev_b2  = 1'b0;
  logic done2    = 1'b0;

  always @(negedge sys_clk) begin
    if (tx2 != prev_tx2) edges2.push_back(cyc);
    if (f2_rd_en) rd2_cnt++;
    if (prev_b2 && !busy2 && b2_fall < 0) b2_fall = cyc;
    prev_tx2 = tx2;
    prev_b2  = busy2;
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    mem[n_push % 64] = b;
    n_push++;
  endtask

  initial begin : slow_baud
    int runs[$];
    logic cur, b;
    int len, e_end;
    @(posedge rst2_n);
    step(2);
    p2_push = 1;
    for (int i = 0; i < 60000 && b2_fall < 0; i++) @(posedge sys_clk);
    chk("b9600_frame_done", int'(b2_fall >= 0), 1);
    cur = fbit(8'h55, 0);
    len = 1;
    for (int k = 1; k < NB; k++) begin
      b = fbit(8'h55, k);
      if (b == cur) len++;
      else begin
        runs.push_back(len);
        cur = b;
        len = 1;
      end
    end
    runs.push_back(len);
    chk("b9600_rd_count", rd2_cnt, 1);
    chk("b9600_edge_count", edges2.size(), runs.size());
    for (int i = 0; i < runs.size() && i < edges2.size(); i++) begin
      e_end = (i + 1 < edges2.size()) ? edges2[i + 1] : b2_fall;
      chk("b9600_bit_len", e_end - edges2[i], runs[i] * DIV2);
    end
    done2 = 1'b1;
  end

  initial begin : main
    int r0, f0, b0, s, s2, cnt, c0, target;
    logic [8:0] lit55;
    logic [8:0] lit12;
    lit55 = 9'h0AA;  // start,1,0,1,0,1,0,1,0
    lit12 = 9'h024;  // start,0,1,0,0,1,0,0,0

    step(3);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", fifo_rd_en, 0);
    sys_rst_n = 1'b1;
    rst2_n    = 1'b1;
    step(5);

    // Single byte 0x55.
    r0 = rd_times.size(); f0 = falls.size(); b0 = busy_falls.size();
    push(8'h55);
    step(FRAME + 20);
    chk("single_rd_count", rd_times.size() - r0, 1);
    if (rd_times.size() > r0 && falls.size() > f0 && busy_falls.size() > b0) begin
      s = falls[f0];
      chk("single_start_after_rd", s - rd_times[r0], 2);
      chk("single_busy_fall", busy_falls[b0] - s, NB * DIV);
      chk("single_start_last", txh[s + DIV - 1], 0);
      chk("single_bit0_first", txh[s + DIV], 1);
      for (int k = 0; k < 9; k++) chk("single_bit", txh[s + k * DIV + DIV / 2], lit55[k]);
      chk("single_stop", txh[s + (NB - 1) * DIV + DIV / 2], 1);
    end else begin
      chk("single_frame_seen", 0, 1);
    end

    // Back-to-back 0xA5, 0x3C.
    r0 = rd_times.size(); b0 = busy_falls.size();
    push(8'hA5);
    push(8'h3C);
    step(2 * FRAME + 20);
    chk("b2b_rd_count", rd_times.size() - r0, 2);
    if (rd_times.size() >= r0 + 2) begin
      s = rd_times[r0] + 2;
      chk("b2b_second_rd", rd_times[r0 + 1], s + NB * DIV);
      s2 = rd_times[r0 + 1] + 2;
      chk("b2b_gap_tx", {txh[s2 - 2], txh[s2 - 1], txh[s2]}, 3'b110);
      cnt = 0;
      for (int c = rd_times[r0]; c < s2 + NB * DIV; c++) if (!bh[c]) cnt++;
      chk("b2b_busy_low_cycles", cnt, 0);
      chk("b2b_busy_falls", busy_falls.size() - b0, 1);
    end else begin
      chk("b2b_frames_seen", 0, 1);
    end

    // Empty FIFO for 10000 cycles.
    r0 = rd_times.size();
    c0 = cyc;
    step(10000);
    cnt = 0;
    for (int c = c0; c < c0 + 10000; c++) if (!txh[c] || bh[c]) cnt++;
    chk("idle_rd_count", rd_times.size() - r0, 0);
    chk("idle_active_cycles", cnt, 0);

    // Reset during data bit 3 of 0xF0.
    f0 = falls.size();
    push(8'hF0);
    step(5);
    if (falls.size() > f0) begin
      s = falls[f0];
      target = s + 4 * DIV + DIV / 2;
      while (cyc < target) @(posedge sys_clk);
      #2;
      chk("pre_rst_tx", tx, 0);
      sys_rst_n = 1'b0;
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
    end else begin
      chk("rst_frame_seen", 0, 1);
    end
    step(3);
    sys_rst_n = 1'b1;
    r0 = rd_times.size();
    step(2000);
    chk("post_rst_no_rd", rd_times.size() - r0, 0);

    r0 = rd_times.size(); f0 = falls.size(); b0 = busy_falls.size();
    push(8'h12);
    step(FRAME + 20);
    chk("post_rst_rd_count", rd_times.size() - r0, 1);
    if (falls.size() > f0 && busy_falls.size() > b0) begin
      s = falls[f0];
      for (int k = 0; k < 9; k++) chk("post_rst_bit", txh[s + k * DIV + DIV / 2], lit12[k]);
      chk("post_rst_frame_len", busy_falls[b0] - s, NB * DIV);
    end else begin
      chk("post_rst_frame_seen", 0, 1);
    end

`ifdef UART_TX_PARITY_EN
    f0 = falls.size(); b0 = busy_falls.size();
    push(8'h07);
    step(FRAME + 20);
    if (falls.size() > f0 && busy_falls.size() > b0) begin
      s = falls[f0];
      chk("parity_07", txh[s + 9 * DIV + DIV / 2], 1);
      chk("parity_frame_len", busy_falls[b0] - s, 11 * 434);
    end else begin
      chk("parity_07_seen", 0, 1);
    end
    f0 = falls.size();
    push(8'h03);
    step(FRAME + 20);
    if (falls.size() > f0) begin
      s = falls[f0];
      chk("parity_03", txh[s + 9 * DIV + DIV / 2], 0);
    end else begin
      chk("parity_03_seen", 0, 1);
    end
`endif

    for (int i = 0; i < 70000 && !done2; i++) step(1);
    chk("b9600_finished", done2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
